uart_mem_loader: RTL and testbench

//  Host-to-core path: receives a program image over UART (8N1) and writes it word-by-word into core memory.

---
 rtl/loader_pkg.sv | 14 +
 rtl/uart_rx_byte.sv | 83 ++++++++
 rtl/uart_mem_loader.sv | 136 +++++++++++++
 tb/tb_uart_mem_loader.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
package loader_pkg;

  localparam int LEN_BYTES  = 4;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {L_LEN, L_DATA, L_CSUM, L_DONE, L_ERR} ld_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchroniser, mid-bit sampling, start-glitch rejection.
module uart_rx_byte
  import loader_pkg::*;
#(
  parameter int CLK_FREQ = 25000000,
  parameter int BAUD     = 115200
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(CPB + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);

  logic            sync1_q, sync2_q, prev_q;
  rx_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shreg_q;
  logic            bit_end, half_end;

  assign bit_end  = (cnt_q == BIT_LAST);
  assign half_end = (cnt_q == HALF_LAST);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
    end
  end

  // Counter restarts on every state change and at each bit boundary.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      if (state_d != state_q || state_q == RX_IDLE || bit_end) cnt_q <= '0;
      else                                                     cnt_q <= cnt_q + 1'b1;
      if (state_q == RX_DATA && bit_end) begin
        shreg_q <= {sync2_q, shreg_q[7:1]};
        bit_q   <= bit_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:  if (prev_q && !sync2_q) state_d = RX_START;
      RX_START: if (half_end) state_d = sync2_q ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_end && bit_q == 3'd7) state_d = RX_STOP;
      RX_STOP:  if (bit_end) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    if (state_q == RX_STOP && bit_end) begin
      byte_valid = sync2_q;
      frame_err  = !sync2_q;
    end
  end

  assign byte_data = shreg_q;

endmodule

// File: rtl/uart_mem_loader.sv
// Loads a length-prefixed program image from UART into word memory, holding the core in reset.
// Optional trailer checksum byte enabled by defining LOADER_CHECKSUM_EN.
module uart_mem_loader
  import loader_pkg::*;
#(
  parameter int CLK_FREQ = 25000000,
  parameter int BAUD     = 115200,
  parameter int ADDR_W   = 14
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              rxd,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [32:0] MAX_N = 33'(1) << ADDR_W;
`ifdef LOADER_CHECKSUM_EN
  localparam ld_state_t AFTER_DATA = L_CSUM;
`else
  localparam ld_state_t AFTER_DATA = L_DONE;
`endif

  logic        byte_valid, frame_err;
  logic [7:0]  byte_data;

  uart_rx_byte #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
    .CLK        (CLK),
    .RST        (RST),
    .rxd        (rxd),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  ld_state_t         st_q, st_d;
  logic [1:0]        bcnt_q;
  logic [31:0]       len_q;
  logic [23:0]       word_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W:0]   addr_q;
  logic              we_q;
  logic [31:0]       len_full, word_full;
  logic              last_write;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  assign len_full   = {byte_data, len_q[31:8]};
  assign word_full  = {byte_data, word_q};
  // Address is one bit wider than the memory so N == 2**ADDR_W ends without wrapping.
  assign last_write = we_q && ((addr_q + 1'b1) == len_q[ADDR_W:0]);

  always_ff @(posedge CLK) begin
    if (!RST) st_q <= L_LEN;
    else      st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      L_LEN: begin
        if (frame_err) st_d = L_ERR;
        else if (byte_valid && bcnt_q == 2'(LEN_BYTES - 1)) begin
          if ({1'b0, len_full} > MAX_N) st_d = L_ERR;
          else if (len_full == 32'd0)   st_d = AFTER_DATA;
          else                          st_d = L_DATA;
        end
      end
      L_DATA: begin
        if (frame_err)       st_d = L_ERR;
        else if (last_write) st_d = AFTER_DATA;
      end
      L_CSUM: begin
        if (frame_err) st_d = L_ERR;
`ifdef LOADER_CHECKSUM_EN
        else if (byte_valid) st_d = (8'(csum_q + byte_data) == 8'h00) ? L_DONE : L_ERR;
`endif
      end
      default: st_d = st_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      bcnt_q  <= '0;
      len_q   <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      if (we_q) addr_q <= addr_q + 1'b1;
      if (byte_valid) begin
        case (st_q)
          L_LEN: begin
            len_q  <= len_full;
            bcnt_q <= bcnt_q + 1'b1;
          end
          L_DATA: begin
            word_q <= word_full[31:8];
            bcnt_q <= bcnt_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
            csum_q <= csum_q + byte_data;
`endif
            if (bcnt_q == 2'(WORD_BYTES - 1)) begin
              we_q    <= 1'b1;
              wdata_q <= word_full;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    mem_we     = we_q;
    mem_addr   = addr_q[ADDR_W-1:0];
    mem_wdata  = wdata_q;
    done       = (st_q == L_DONE);
    core_rst_n = (st_q == L_DONE);
    err        = (st_q == L_ERR);
    busy       = (st_q == L_LEN && bcnt_q != 2'd0) || st_q == L_DATA || st_q == L_CSUM;
  end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Scoreboard bench: stimulus pushes expected writes, a negedge monitor pops and compares.
module tb_uart_mem_loader;

  localparam int CLK_FREQ = 25000000;
  // Twice the default bit rate keeps the run short; half a bit (54 clks) still exceeds the 50-clk glitch.
  localparam int BAUD     = 230400;
  localparam int ADDR_W   = 14;
  localparam int CPB      = CLK_FREQ / BAUD;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              rxd = 1'b1;
  logic              mem_we, core_rst_n, busy, done, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  uart_mem_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADDR_W(ADDR_W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .rxd        (rxd),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #20 CLK = ~CLK;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (RST && mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write addr=%0h data=%0h", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 64'(mem_addr), 64'(e.addr));
        chk("wr_data", 64'(mem_wdata), 64'(e.data));
      end
    end
  end

  task automatic bit_time(input logic v);
    rxd = v;
    repeat (CPB) @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop_ok);
    rxd = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
  endtask

  // Reference model: word i lands at address i; trailer makes the data-byte sum 0 mod 256.
  task automatic send_image(input logic [31:0] w[$]);
    int sum;
    sum = 0;
    send_word(32'(w.size()));
    foreach (w[i]) begin
      exp_q.push_back({ADDR_W'(i), w[i]});
      send_word(w[i]);
      for (int k = 0; k < 4; k++) sum += int'((w[i] >> (8 * k)) & 32'hff);
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'((256 - (sum % 256)) % 256), 1'b1);
`else
    if (sum < 0) $display("negative sum");
`endif
  endtask

  task automatic do_reset(input string name);
    @(posedge CLK); #1;
    RST = 1'b0;
    rxd = 1'b1;
    exp_q.delete();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk(name, {13'd0, mem_we, mem_addr, mem_wdata, core_rst_n, busy, done, err}, 64'd0);
    @(posedge CLK); #1;
    RST = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
  endtask

  task automatic expect_end(input string name, input bit exp_done, input bit exp_err);
    int n;
    n = 0;
    while (!(done === 1'b1 || err === 1'b1) && n < 8) begin
      @(posedge CLK);
      n++;
    end
    @(negedge CLK);
    chk(name, {60'd0, done, err, core_rst_n, busy}, {60'd0, exp_done, exp_err, exp_done, 1'b0});
    chk({name, "_pending"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #(200000 * 40);
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] img[$];

    do_reset("reset_state");

    // Fixed two-word image.
    img.delete();
    img.push_back(32'hDEADBEEF);
    img.push_back(32'h00000013);
    send_image(img);
    expect_end("two_word_load", 1'b1, 1'b0);

    // Empty image: done straight after the length (and trailer).
    do_reset("reset_before_empty");
    img.delete();
    send_image(img);
    @(negedge CLK);
    chk("empty_done_prompt", {62'd0, done, err}, {62'd0, 1'b1, 1'b0});
    expect_end("empty_load", 1'b1, 1'b0);

    // Framing error on the third byte of the first word, then more traffic.
    do_reset("reset_before_frame");
    send_word(32'd2);
    send_byte(8'hEF, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hAD, 1'b0);
    repeat (4) @(posedge CLK);
    expect_end("frame_err", 1'b0, 1'b1);
    send_byte(8'hDE, 1'b1);
    expect_end("frame_err_sticky", 1'b0, 1'b1);

    // Length beyond the memory size.
    do_reset("reset_before_overlen");
    send_word(32'h00004001);
    expect_end("over_length", 1'b0, 1'b1);

    // Short low glitch must not register as a byte.
    do_reset("reset_before_glitch");
    rxd = 1'b0;
    repeat (50) @(posedge CLK);
    #1;
    rxd = 1'b1;
    repeat (2 * CPB) @(posedge CLK);
    @(negedge CLK);
    chk("glitch_ignored", {61'd0, busy, done, err}, 64'd0);
    img.delete();
    img.push_back($urandom);
    send_image(img);
    expect_end("load_after_glitch", 1'b1, 1'b0);

    // Abort after five bytes of a two-word load, then resend the whole image.
    do_reset("reset_before_abort");
    img.delete();
    img.push_back($urandom);
    img.push_back($urandom);
    send_word(32'd2);
    send_byte(img[0][7:0], 1'b1);
    @(negedge CLK);
    chk("busy_mid_load", {62'd0, busy, done}, {62'd0, 1'b1, 1'b0});
    do_reset("reset_mid_load");
    send_image(img);
    expect_end("reload", 1'b1, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    // Wrong trailer: 0x01+0x02+0x03+0x04 needs 0xF6, 0xFF sent.
    do_reset("reset_before_bad_csum");
    send_word(32'd1);
    exp_q.push_back({ADDR_W'(0), 32'h01020304});
    send_word(32'h01020304);
    send_byte(8'hFF, 1'b1);
    expect_end("bad_checksum", 1'b0, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
